dvfs_budget_arbiter: RTL and testbench

Chip-level arbiter that shares one global power budget and one shared voltage-regulator (VR) command port among `NUM_SM` per-SM self-optimizing controllers. It round-robin scans each SM's requested DVFS level and grants one-level steps only when the projected power stays within budget. Every level change is sequenced through a req/ack handshake with the VR. It sits between the SM controllers' `dvfs_req` outputs and the board power-management interface.

---
 rtl/dvfs_budget_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_dvfs_budget_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dvfs_budget_arbiter.sv
// dvfs_budget_arbiter
//
// Shares one global power budget and one voltage-regulator command port
// among NUM_SM per-SM DVFS controllers. A pointer scans the SMs round-robin
// at one SM per cycle. Each scan can shed a level (over budget), step up
// (within budget), or step down (the request is below the grant). Every
// change is one level and goes through a vr_req/vr_ack handshake before the
// grant and the committed power total are updated.
//
// Optional feature macro: DVFS_ARB_TIMEOUT_EN
//   defined   : VR_WAIT is bounded by TIMEOUT cycles. An unacked command is
//               dropped and vr_timeout_err sets until reset.
//   undefined : VR_WAIT waits for vr_ack indefinitely; vr_timeout_err is 0.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   sm_dvfs_req     requested level per SM, SM i at [2i+1:2i]
//   global_budget   power budget, sampled every cycle
//   vr_ack          VR accepted the pending command
//   sm_dvfs_grant   granted level per SM, same packing as sm_dvfs_req
//   vr_req          VR command valid
//   vr_sm           SM index of the pending command
//   vr_level        target level of the pending command
//   committed       NUM_SM*BASE_COST + LVL_COST*sum(grants), registered
//   vr_timeout_err  sticky VR no-ack error
module dvfs_budget_arbiter #(
  parameter int          NUM_SM    = 4,
  parameter logic [15:0] BASE_COST = 16'd40,
  parameter logic [15:0] LVL_COST  = 16'd30,
  parameter logic [7:0]  TIMEOUT   = 8'd64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [2*NUM_SM-1:0]   sm_dvfs_req,
  input  logic [15:0]           global_budget,
  input  logic                  vr_ack,
  output logic [2*NUM_SM-1:0]   sm_dvfs_grant,
  output logic                  vr_req,
  output logic [3:0]            vr_sm,
  output logic [1:0]            vr_level,
  output logic [19:0]           committed,
  output logic                  vr_timeout_err
);

  localparam int          PTR_W      = $clog2(NUM_SM);
  localparam logic [19:0] LVL20      = {4'b0, LVL_COST};
  localparam logic [19:0] BASE20     = {4'b0, BASE_COST};
  localparam logic [19:0] COMMIT_RST = 20'(NUM_SM) * BASE20;

  typedef enum logic {
    SCAN    = 1'b0,
    VR_WAIT = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d, ptr_next;
  logic [PTR_W-1:0]   vr_sm_q, vr_sm_d;
  logic [1:0]         vr_level_q, vr_level_d;
  logic               vr_up_q, vr_up_d;
  logic [1:0]         grant_q [NUM_SM];
  logic [1:0]         grant_d [NUM_SM];
  logic [1:0]         req_a   [NUM_SM];
  logic [19:0]        committed_q, committed_d;
  logic [19:0]        budget20;
  logic [1:0]         cur_grant, cur_req, tgt;
  logic               act, up, over_budget, headroom;

`ifdef DVFS_ARB_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = TIMEOUT - 8'd1;
  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;
`endif

  always_comb begin
    for (int unsigned i = 0; i < NUM_SM; i++) begin
      req_a[i] = sm_dvfs_req[2*i +: 2];
    end
  end

  always_comb begin
    sm_dvfs_grant = '0;
    for (int unsigned i = 0; i < NUM_SM; i++) begin
      sm_dvfs_grant[2*i +: 2] = grant_q[i];
    end
  end

  assign budget20    = {4'b0, global_budget};
  assign cur_grant   = grant_q[ptr_q];
  assign cur_req     = req_a[ptr_q];
  assign over_budget = committed_q > budget20;
  assign headroom    = (committed_q + LVL20) <= budget20;
  assign ptr_next    = (ptr_q == PTR_W'(NUM_SM - 1)) ? '0 : ptr_q + PTR_W'(1);

  // State register and all datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SCAN;
      ptr_q       <= '0;
      vr_sm_q     <= '0;
      vr_level_q  <= '0;
      vr_up_q     <= 1'b0;
      committed_q <= COMMIT_RST;
      for (int unsigned i = 0; i < NUM_SM; i++) begin
        grant_q[i] <= '0;
      end
`ifdef DVFS_ARB_TIMEOUT_EN
      cnt_q       <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      vr_sm_q     <= vr_sm_d;
      vr_level_q  <= vr_level_d;
      vr_up_q     <= vr_up_d;
      committed_q <= committed_d;
      for (int unsigned i = 0; i < NUM_SM; i++) begin
        grant_q[i] <= grant_d[i];
      end
`ifdef DVFS_ARB_TIMEOUT_EN
      cnt_q       <= cnt_d;
      err_q       <= err_d;
`endif
    end
  end

  // Next-state logic: scan decision, handshake completion, optional watchdog
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    vr_sm_d     = vr_sm_q;
    vr_level_d  = vr_level_q;
    vr_up_d     = vr_up_q;
    committed_d = committed_q;
    grant_d     = grant_q;
    tgt         = cur_grant;
    act         = 1'b0;
    up          = 1'b0;
`ifdef DVFS_ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
    err_d       = err_q;
`endif

    case (state_q)
      SCAN: begin
        // Priority: shed, then step up, then step down
        if (over_budget && (cur_grant != 2'd0)) begin
          act = 1'b1;
          tgt = cur_grant - 2'd1;
        end else if ((cur_req > cur_grant) && headroom) begin
          act = 1'b1;
          up  = 1'b1;
          tgt = cur_grant + 2'd1;
        end else if (cur_req < cur_grant) begin
          act = 1'b1;
          tgt = cur_grant - 2'd1;
        end

        if (act) begin
          vr_sm_d    = ptr_q;
          vr_level_d = tgt;
          vr_up_d    = up;
          state_d    = VR_WAIT;
`ifdef DVFS_ARB_TIMEOUT_EN
          cnt_d      = '0;
`endif
        end else begin
          ptr_d = ptr_next;
        end
      end

      VR_WAIT: begin
        if (vr_ack) begin
          grant_d[vr_sm_q] = vr_level_q;
          committed_d      = vr_up_q ? committed_q + LVL20 : committed_q - LVL20;
          ptr_d            = ptr_next;
          state_d          = SCAN;
`ifdef DVFS_ARB_TIMEOUT_EN
        // An ack in the expiry cycle takes the branch above, so ack wins
        end else if (cnt_q == TO_LAST) begin
          ptr_d   = ptr_next;
          state_d = SCAN;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
`endif
        end
      end

      default: state_d = SCAN;
    endcase
  end

  assign vr_req    = (state_q == VR_WAIT);
  assign vr_sm     = 4'(vr_sm_q);
  assign vr_level  = vr_level_q;
  assign committed = committed_q;

`ifdef DVFS_ARB_TIMEOUT_EN
  assign vr_timeout_err = err_q;
`else
  // TIMEOUT only matters when the watchdog is built in
  assign vr_timeout_err = 1'b0 & (TIMEOUT != 8'd0);
`endif

endmodule

// File: tb/tb_dvfs_budget_arbiter.sv
// Testbench for dvfs_budget_arbiter (NUM_SM=4, BASE 40, LVL 30, TIMEOUT 64).
// Expected VR commands (SM, level, committed after ack) are queued as each
// scenario's stimulus is applied and compared as the DUT raises vr_req.
module tb_dvfs_budget_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  sm_dvfs_req = '0;
  logic [15:0] global_budget = 16'd1000;
  logic        vr_ack = 1'b0;
  logic [7:0]  sm_dvfs_grant;
  logic        vr_req;
  logic [3:0]  vr_sm;
  logic [1:0]  vr_level;
  logic [19:0] committed;
  logic        vr_timeout_err;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0]  sm;
    logic [1:0]  lvl;
    logic [19:0] com;
  } cmd_t;

  cmd_t exp_q[$];
  int   exp_grant [4];
  int   exp_commit;

  dvfs_budget_arbiter #(
    .NUM_SM    (4),
    .BASE_COST (16'd40),
    .LVL_COST  (16'd30),
    .TIMEOUT   (8'd64)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .sm_dvfs_req    (sm_dvfs_req),
    .global_budget  (global_budget),
    .vr_ack         (vr_ack),
    .sm_dvfs_grant  (sm_dvfs_grant),
    .vr_req         (vr_req),
    .vr_sm          (vr_sm),
    .vr_level       (vr_level),
    .committed      (committed),
    .vr_timeout_err (vr_timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic logic [1:0] grant_of(input int sm);
    return sm_dvfs_grant[2*sm +: 2];
  endfunction

  task automatic model_clear();
    exp_q.delete();
    exp_commit = 160;
    for (int i = 0; i < 4; i++) exp_grant[i] = 0;
  endtask

  task automatic push_cmd(input int sm, input int lvl);
    cmd_t c;
    if (lvl > exp_grant[sm]) exp_commit += 30;
    else                     exp_commit -= 30;
    exp_grant[sm] = lvl;
    c.sm  = 4'(sm);
    c.lvl = 2'(lvl);
    c.com = 20'(exp_commit);
    exp_q.push_back(c);
  endtask

  task automatic do_reset(input logic [7:0] req, input logic [15:0] bud);
    @(negedge clk);
    rst_n         = 1'b0;
    vr_ack        = 1'b0;
    sm_dvfs_req   = req;
    global_budget = bud;
    model_clear();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Acks n commands one cycle after each vr_req rise; checks each command
  // against the scoreboard and the grant/committed result after the ack.
  task automatic serve(input int n, input int max_cycles);
    int   served = 0;
    int   cyc = 0;
    bit   pend = 1'b0;
    cmd_t cur;
    while ((served < n || pend) && cyc < max_cycles) begin
      @(negedge clk);
      cyc++;
      vr_ack = 1'b0;
      if (pend) begin
        check("ack_committed", committed, cur.com);
        check("ack_grant", grant_of(int'(cur.sm)), cur.lvl);
        check("ack_vr_req_low", vr_req, 0);
        pend = 1'b0;
      end
      if (vr_req && served < n) begin
        served++;
        vr_ack = 1'b1;
        if (exp_q.size() == 0) begin
          check("sb_unexpected_cmd", 0, 1);
        end else begin
          cur = exp_q.pop_front();
          check("cmd_sm", vr_sm, cur.sm);
          check("cmd_level", vr_level, cur.lvl);
          pend = 1'b1;
        end
      end
    end
    vr_ack = 1'b0;
    if (cyc >= max_cycles) check("serve_cycle_budget", served, n);
  endtask

  // Waits for vr_req without acking, checks the command against the queue
  task automatic wait_req(input int max_cycles);
    cmd_t cur;
    bit   seen = 1'b0;
    for (int c = 0; c < max_cycles && !seen; c++) begin
      @(negedge clk);
      if (vr_req) seen = 1'b1;
    end
    if (!seen) begin
      check("wait_req_timeout", 0, 1);
    end else if (exp_q.size() == 0) begin
      check("sb_unexpected_cmd", 0, 1);
    end else begin
      cur = exp_q.pop_front();
      check("cmd_sm", vr_sm, cur.sm);
      check("cmd_level", vr_level, cur.lvl);
    end
  endtask

  task automatic watch_idle(input int n);
    int seen = 0;
    repeat (n) begin
      @(negedge clk);
      if (vr_req) seen++;
    end
    check("idle_vr_req", seen, 0);
  endtask

  initial begin
    int hi_cnt;

    // Reset state, no requests
    do_reset(8'h00, 16'd1000);
    check("rst_grant", sm_dvfs_grant, 0);
    check("rst_committed", committed, 160);
    check("rst_vr_req", vr_req, 0);
    check("rst_vr_sm", vr_sm, 0);
    check("rst_vr_level", vr_level, 0);
    check("rst_err", vr_timeout_err, 0);
    watch_idle(20);
    check("idle_committed", committed, 160);

    // SM2 climbs 0 -> 3 in three single-step handshakes
    do_reset(8'h30, 16'd1000);
    for (int l = 1; l <= 3; l++) push_cmd(2, l);
    serve(3, 100);
    check("sm2_grant", sm_dvfs_grant, 8'h30);
    check("sm2_committed", committed, 250);
    watch_idle(12);

    // Budget 250 caps the total at three levels, round-robin from SM0
    do_reset(8'hFF, 16'd250);
    for (int s = 0; s < 3; s++) push_cmd(s, 1);
    serve(3, 100);
    watch_idle(40);
    check("cap_grant", sm_dvfs_grant, 8'h15);
    check("cap_committed", committed, 250);

    // Fill everything to level 3, then drop the budget to 300 and shed
    do_reset(8'hFF, 16'd1000);
    for (int l = 1; l <= 3; l++)
      for (int s = 0; s < 4; s++) push_cmd(s, l);
    serve(12, 300);
    global_budget = 16'd300;
    check("full_grant", sm_dvfs_grant, 8'hFF);
    check("full_committed", committed, 520);
    for (int l = 2; l >= 1; l--)
      for (int s = 0; s < 4; s++) push_cmd(s, l);
    serve(8, 300);
    watch_idle(40);
    check("shed_grant", sm_dvfs_grant, 8'h55);
    check("shed_committed", committed, 280);

    // No ack: watchdog drop when built in, otherwise vr_req holds
    do_reset(8'h04, 16'd1000);
    push_cmd(1, 1);
    wait_req(20);
    hi_cnt = 1;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (!vr_req) break;
      hi_cnt++;
    end
`ifdef DVFS_ARB_TIMEOUT_EN
    check("to_req_cycles", hi_cnt, 64);
    check("to_err", vr_timeout_err, 1);
    check("to_grant", sm_dvfs_grant, 0);
    check("to_committed", committed, 160);
`else
    check("hold_vr_req", vr_req, 1);
    check("hold_err", vr_timeout_err, 0);
    check("hold_grant", sm_dvfs_grant, 0);
`endif

    // Async reset in the middle of a handshake
    do_reset(8'h20, 16'd1000);
    push_cmd(2, 1);
    push_cmd(2, 2);
    serve(1, 50);
    wait_req(20);
    sm_dvfs_req = 8'h55;
    rst_n = 1'b0;
    #1;
    check("arst_vr_req", vr_req, 0);
    check("arst_grant", sm_dvfs_grant, 0);
    check("arst_committed", committed, 160);
    check("arst_vr_sm", vr_sm, 0);
    check("arst_vr_level", vr_level, 0);
    repeat (2) @(negedge clk);
    model_clear();
    push_cmd(0, 1);
    rst_n = 1'b1;
    serve(1, 20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
